uart_rx: RTL and testbench

Serial UART receiver, the receive end of the board UART link: it turns the 8N1 stream on the `RsRx` pin back into bytes, for the same frame format that `uart_tx` drives. Received bytes sit in a one-byte holding register with a valid/ack handshake. Game logic can therefore take commands from the host PC (start, difficulty, reset) alongside the PS/2 keyboard. Framing errors and overruns are flagged as single-cycle pulses.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_if.sv | 14 +
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 122 ++++++++++++
 tb/tb_uart_rx.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: frame format, default baud divider, and receiver state encoding.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT_9600 = 10416;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte handshake: holding register, valid/ack, and error pulses.
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rdata;
  logic                 rvalid;
  logic                 rack;
  logic                 frame_err;
  logic                 overrun;

  modport master (output rdata, output rvalid, output frame_err, output overrun, input rack);
  modport slave  (input rdata, input rvalid, input frame_err, input overrun, output rack);

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for single-bit asynchronous inputs.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-byte holding register and framing/overrun pulses.
//
// state        | meaning
// ST_IDLE      | waiting for rx_s low (start edge)
// ST_START     | half-bit delay, then re-check start bit
// ST_DATA      | sampling 8 data bits at mid-bit, LSB first
// ST_STOP      | sampling stop bit, commit or flag
// ST_WAIT_IDLE | after framing error, wait for line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_9600,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      rx,
  output logic      busy,
  uart_rx_if.master rif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT    = 3'(DATA_BITS - 1);

  logic                 rx_s;
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [2:0]           bitidx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] rdata_q;
  logic                 rvalid_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bitidx      <= '0;
      shreg       <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (rvalid_q && rif.rack)
        rvalid_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            cnt   <= HALF_RELOAD;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx_s) begin
            state <= ST_IDLE;
          end else begin
            cnt    <= BIT_RELOAD;
            bitidx <= '0;
            state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg[bitidx] <= rx_s;
            cnt           <= BIT_RELOAD;
            if (bitidx == LAST_BIT)
              state <= ST_STOP;
            else
              bitidx <= bitidx + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx_s) begin
            state <= ST_IDLE;
            // An ack in the same cycle frees the register for the new byte.
            if (!rvalid_q || rif.rack) begin
              rdata_q  <= shreg;
              rvalid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end else begin
            frame_err_q <= 1'b1;
            state       <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_s)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy          = (state != ST_IDLE);
  assign rif.rdata     = rdata_q;
  assign rif.rvalid    = rvalid_q;
  assign rif.frame_err = frame_err_q;
  assign rif.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; rx is driven by the bench's own bit timer.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic clk;
  logic reset_n;
  logic rx;
  logic busy;

  int checks = 0;
  int errors = 0;

  int fe_cnt = 0, fe_run = 0, fe_maxrun = 0;
  int ov_cnt = 0, ov_run = 0, ov_maxrun = 0;
  int busy_cyc = 0;

  uart_rx_if rif ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .busy    (busy),
    .rif     (rif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    fe_run = rif.frame_err ? fe_run + 1 : 0;
    ov_run = rif.overrun ? ov_run + 1 : 0;
    if (rif.frame_err) fe_cnt++;
    if (rif.overrun) ov_cnt++;
    if (fe_run > fe_maxrun) fe_maxrun = fe_run;
    if (ov_run > ov_maxrun) ov_maxrun = ov_run;
    if (busy) busy_cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start + data bits and leaves rx at the stop level; returns as the stop bit begins.
  task automatic drive_bits(input logic [7:0] b, input int per, input logic stop_lvl);
    rx = 1'b0;
    tick(per);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      tick(per);
    end
    rx = stop_lvl;
  endtask

  task automatic ack();
    rif.rack = 1'b1;
    tick(1);
    rif.rack = 1'b0;
  endtask

  logic [7:0] got [3];
  int fe0, ov0, busy0, wait_n;
  logic timed_out;

  initial begin
    reset_n  = 1'b0;
    rx       = 1'b1;
    rif.rack = 1'b0;
    #2;
    chk("reset_rdata", 32'(rif.rdata), 32'h00);
    chk("reset_rvalid", 32'(rif.rvalid), 32'h0);
    chk("reset_frame_err", 32'(rif.frame_err), 32'h0);
    chk("reset_overrun", 32'(rif.overrun), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    tick(3);
    reset_n = 1'b1;
    tick(5);

    // Single frame: rx falls just after edge E; stop sampled at E+155, rvalid visible right after it.
    fe0 = fe_cnt; ov0 = ov_cnt;
    drive_bits(8'h5A, CPB, 1'b1);
    tick(10);
    chk("single_rvalid_early", 32'(rif.rvalid), 32'h0);
    tick(1);
    chk("single_rvalid_on_time", 32'(rif.rvalid), 32'h1);
    chk("single_rdata", 32'(rif.rdata), 32'h5A);
    tick(5);
    chk("single_no_flags", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);
    ack();
    chk("single_rvalid_after_ack", 32'(rif.rvalid), 32'h0);
    chk("single_rdata_held", 32'(rif.rdata), 32'h5A);
    tick(1);
    rif.rack = 1'b1;
    tick(1);
    rif.rack = 1'b0;
    chk("rack_while_empty_ignored", 32'(rif.rvalid), 32'h0);
    tick(10);

    // Back-to-back frames, acked as soon as each byte appears.
    fe0 = fe_cnt; ov0 = ov_cnt;
    timed_out = 1'b0;
    fork
      begin
        drive_bits(8'h01, CPB, 1'b1); tick(CPB);
        drive_bits(8'h80, CPB, 1'b1); tick(CPB);
        drive_bits(8'hFF, CPB, 1'b1); tick(CPB);
      end
      begin
        for (int i = 0; i < 3; i++) begin
          wait_n = 0;
          while (!rif.rvalid && wait_n < 400) begin
            tick(1);
            wait_n++;
          end
          if (wait_n >= 400) timed_out = 1'b1;
          got[i] = rif.rdata;
          ack();
        end
      end
    join
    chk("b2b_no_timeout", 32'(timed_out), 32'h0);
    chk("b2b_byte0", 32'(got[0]), 32'h01);
    chk("b2b_byte1", 32'(got[1]), 32'h80);
    chk("b2b_byte2", 32'(got[2]), 32'hFF);
    chk("b2b_no_overrun", 32'(ov_cnt - ov0), 32'd0);
    chk("b2b_no_frame_err", 32'(fe_cnt - fe0), 32'd0);
    tick(10);

    // Overrun: second byte arrives while the first is still unacknowledged.
    ov0 = ov_cnt; ov_maxrun = 0;
    drive_bits(8'h11, CPB, 1'b1); tick(CPB);
    drive_bits(8'h22, CPB, 1'b1); tick(CPB);
    tick(5);
    chk("ovr_pulse_count", 32'(ov_cnt - ov0), 32'd1);
    chk("ovr_pulse_width", 32'(ov_maxrun), 32'd1);
    chk("ovr_rdata_kept", 32'(rif.rdata), 32'h11);
    chk("ovr_rvalid_kept", 32'(rif.rvalid), 32'h1);
    ack();
    tick(5);

    // Glitch: 4 low cycles; START lasts exactly HALF cycles then returns to IDLE.
    fe0 = fe_cnt; ov0 = ov_cnt; busy0 = busy_cyc;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(20);
    chk("glitch_busy_cycles", 32'(busy_cyc - busy0), 32'(HALF));
    chk("glitch_idle", 32'(busy), 32'h0);
    chk("glitch_no_flags", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);
    chk("glitch_rvalid", 32'(rif.rvalid), 32'h0);

    // Framing error followed by a break: 40 low cycles from the stop bit onward.
    fe0 = fe_cnt; fe_maxrun = 0;
    drive_bits(8'hA5, CPB, 1'b0);
    tick(40);
    chk("ferr_pulse_count", 32'(fe_cnt - fe0), 32'd1);
    chk("ferr_pulse_width", 32'(fe_maxrun), 32'd1);
    chk("ferr_rvalid", 32'(rif.rvalid), 32'h0);
    chk("ferr_wait_busy", 32'(busy), 32'h1);
    rx = 1'b1;
    tick(10);
    chk("ferr_back_idle", 32'(busy), 32'h0);
    chk("ferr_no_retrigger", 32'(fe_cnt - fe0), 32'd1);
    chk("ferr_rvalid_after", 32'(rif.rvalid), 32'h0);

    // Reset mid-frame during data bit 3, then a clean frame.
    rx = 1'b0;
    tick(CPB);
    for (int k = 0; k < 3; k++) begin
      rx = 1'(8'h3C >> k);
      tick(CPB);
    end
    rx = 1'b1;
    tick(HALF);
    chk("rst_busy_before", 32'(busy), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_rdata", 32'(rif.rdata), 32'h00);
    chk("rst_async_rvalid", 32'(rif.rvalid), 32'h0);
    chk("rst_async_busy", 32'(busy), 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(20);
    fe0 = fe_cnt; ov0 = ov_cnt;
    drive_bits(8'h3C, CPB, 1'b1);
    tick(CPB + 5);
    chk("post_rst_rvalid", 32'(rif.rvalid), 32'h1);
    chk("post_rst_rdata", 32'(rif.rdata), 32'h3C);
    chk("post_rst_no_flags", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);
    ack();
    tick(5);

    // Baud skew: 15- and 17-cycle bit periods.
    drive_bits(8'hC3, 15, 1'b1);
    tick(15 + 20);
    chk("skew15_rvalid", 32'(rif.rvalid), 32'h1);
    chk("skew15_rdata", 32'(rif.rdata), 32'hC3);
    ack();
    tick(5);
    drive_bits(8'hC3, 17, 1'b1);
    tick(17 + 20);
    chk("skew17_rvalid", 32'(rif.rvalid), 32'h1);
    chk("skew17_rdata", 32'(rif.rdata), 32'hC3);
    ack();
    chk("skew_no_flags", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
